req_arbiter: RTL and testbench

// - Shares one priority-encoded resource between N requesters by granting exactly one at a time.
// - Fixed-priority or round-robin selection; the grant is held until release or timeout.
// - Sits in front of the priority encoder datapath; gnt_id drives the shared resource's select/owner field.

---
 rtl/req_arbiter_pkg.sv | 21 ++
 rtl/req_arbiter_if.sv | 41 ++++
 rtl/req_arbiter_pick.sv | 53 +++++
 rtl/req_arbiter.sv | 107 ++++++++++
 tb/tb_req_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/req_arbiter_pkg.sv
// Shared types and helpers for the request arbiter.
//   arb_state_t   : arbiter FSM state (IDLE = no owner, BUSY = grant held)
//   onehot_to_idx : index of the set bit of a one-hot vector (0 if none)
package arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    // The vector is passed zero-extended to 32 bits, so any N up to 32 can
    // share this helper. For a non-one-hot input the highest set bit wins.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/req_arbiter_if.sv
// Handshake bundle between the requesters and the arbiter.
//   req        : request vector, req[N-1] has highest fixed priority
//   done       : holder releases the resource this cycle
//   rr_mode    : 0 = fixed priority, 1 = round-robin (used only when idle)
//   gnt        : one-hot grant, all-zero with no owner
//   gnt_id     : index of the owner, 0 with no owner
//   gnt_valid  : a grant is active
//   timeout    : one-cycle pulse when a grant is forcibly revoked
//   state_dbg  : arbiter FSM state, for observation only
//   rr_ptr_dbg : round-robin search start index, for observation only
// Handshake: a requester holds req[i] high for as long as it wants the
// resource. Ownership starts the cycle gnt[i] is seen high and ends when the
// arbiter drops gnt; the owner ends it early with done or by dropping req[i].
// The master modport is the requester side, slave is the arbiter side.
interface req_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    import arb_pkg::*;

    logic [N-1:0]   req;
    logic           done;
    logic           rr_mode;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           timeout;
    arb_state_t     state_dbg;
    logic [IDW-1:0] rr_ptr_dbg;

    modport master (
        output req, done, rr_mode,
        input  gnt, gnt_id, gnt_valid, timeout, state_dbg, rr_ptr_dbg
    );

    modport slave (
        input  req, done, rr_mode,
        output gnt, gnt_id, gnt_valid, timeout, state_dbg, rr_ptr_dbg
    );

endinterface

// File: rtl/req_arbiter_pick.sv
// Combinational masked priority picker.
//   req     : request vector
//   ptr     : round-robin start index (searched first, then downward)
//   rr_mode : 0 = highest set index wins, 1 = downward search from ptr
//   oh      : one-hot winner (all-zero when req == 0)
//   idx     : index of the winner (0 when req == 0)
//   any     : at least one request is present
module arb_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           rr_mode,
    output logic [N-1:0]   oh,
    output logic [IDW-1:0] idx,
    output logic           any
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] cand;

    // A downward wrapping search from ptr equals: the highest request at or
    // below ptr if there is one, otherwise the highest request overall.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            if (i <= int'(ptr)) begin
                mask[i] = 1'b1;
            end
        end
        masked = req & mask;
        if (rr_mode && (|masked)) begin
            cand = masked;
        end else begin
            cand = req;
        end
        oh = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
    end

    assign idx = IDW'(onehot_to_idx(32'(oh)));
    assign any = |req;

endmodule

// File: rtl/req_arbiter.sv
// Grants one shared resource to one of N requesters at a time.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : req_arbiter_if slave side (requests in, registered grant out)
// Every output is a register; release decisions use the registered owner and
// the current req/done, so there is no combinational path req/done -> output.
// A release always passes through IDLE, giving at least one gnt=0 cycle
// between owners.
module req_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int HOLD_MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    req_arbiter_if.slave bus
);

    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    arb_state_t     state;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           timeout;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  hold_cnt;

    logic [N-1:0]   pick_oh;
    logic [IDW-1:0] pick_idx;
    logic           pick_any;

    logic           holder_req;
    logic           expired;
    logic           release_now;
    logic [IDW-1:0] next_ptr;

    arb_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req     (bus.req),
        .ptr     (rr_ptr),
        .rr_mode (bus.rr_mode),
        .oh      (pick_oh),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    assign holder_req  = bus.req[gnt_id];
    assign expired     = (hold_cnt == HOLD_LAST);
    assign release_now = bus.done || !holder_req || expired;
    // The holder becomes the lowest round-robin priority.
    assign next_ptr    = (gnt_id == '0) ? IDW'(N - 1) : (gnt_id - IDW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt       <= pick_oh;
                        gnt_id    <= pick_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        gnt       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
                        // Only a revoke by the counter alone is a timeout.
                        timeout   <= expired && !bus.done && holder_req;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt;
    assign bus.gnt_id     = gnt_id;
    assign bus.gnt_valid  = gnt_valid;
    assign bus.timeout    = timeout;
    assign bus.state_dbg  = state;
    assign bus.rr_ptr_dbg = rr_ptr;

endmodule

// File: tb/tb_req_arbiter.sv
module tb_req_arbiter;
    import arb_pkg::*;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int HOLD_MAX = 15;
    localparam int W        = N + IDW + 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    req_arbiter_if #(.N(N), .IDW(IDW)) bus ();

    req_arbiter #(
        .N        (N),
        .IDW      (IDW),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Owner index (-1 = nobody), cycles the owner has already held the
    // resource, and the round-robin start index.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_to    = 0;

    function automatic int pick(input logic [N-1:0] r, input bit rr, input int ptr);
        if (!rr) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (r[i]) return i;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (ptr - k + N) % N;
                if (r[j]) return j;
            end
        end
        return -1;
    endfunction

    initial begin
        forever begin
            logic [N-1:0]   g;
            logic [IDW-1:0] id;
            @(posedge clk);
            m_to = 0;
            if (rst) begin
                m_owner = -1;
                m_held  = 0;
                m_ptr   = 0;
            end else if (m_owner < 0) begin
                if (bus.req != '0) begin
                    m_owner = pick(bus.req, bus.rr_mode, m_ptr);
                    m_held  = 1;
                end
            end else begin
                if (bus.done || !bus.req[m_owner] || m_held >= HOLD_MAX) begin
                    m_to    = !bus.done && bus.req[m_owner];
                    m_ptr   = (m_owner + N - 1) % N;
                    m_owner = -1;
                    m_held  = 0;
                end else begin
                    m_held++;
                end
            end
            g  = '0;
            id = '0;
            if (m_owner >= 0) begin
                g[m_owner] = 1'b1;
                id = IDW'(m_owner);
            end
            exp_q.push_back({g, id, (m_owner >= 0), m_to});
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        forever begin
            logic [W-1:0] e;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_gnt", 32'(bus.gnt), 32'(e[W-1 -: N]));
                check("sb_gnt_id", 32'(bus.gnt_id), 32'(e[IDW+1 : 2]));
                check("sb_gnt_valid", 32'(bus.gnt_valid), 32'(e[1]));
                check("sb_timeout", 32'(bus.timeout), 32'(e[0]));
                check("sb_state", 32'(bus.state_dbg), e[1] ? 32'(BUSY) : 32'(IDLE));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input logic [N-1:0] r, input logic d, input logic rr);
        bus.req     = r;
        bus.done    = d;
        bus.rr_mode = rr;
    endtask

    // ---------------- directed stimulus ----------------
    int cnt;
    int rr_exp[5] = '{3, 2, 1, 0, 3};

    initial begin
        rst = 1'b1;
        drive(4'b1111, 1'b0, 1'b0);

        // Reset holds everything low even with all requests up.
        for (int i = 0; i < 2; i++) begin
            step(1);
            check("t1_gnt", 32'(bus.gnt), 0);
            check("t1_gnt_id", 32'(bus.gnt_id), 0);
            check("t1_valid", 32'(bus.gnt_valid), 0);
            check("t1_timeout", 32'(bus.timeout), 0);
        end

        // Fixed priority, done release, regrant after a one-cycle gap.
        rst = 1'b0;
        drive(4'b0110, 1'b0, 1'b0);
        step(1);
        check("t2_gnt", 32'(bus.gnt), 32'h4);
        check("t2_gnt_id", 32'(bus.gnt_id), 2);
        bus.done = 1'b1;
        step(1);
        check("t2_gap", 32'(bus.gnt), 0);
        bus.done = 1'b0;
        step(1);
        check("t2_regrant", 32'(bus.gnt), 32'h4);
        bus.req = '0;
        step(2);

        // Make requester 0 the last holder so round-robin starts from 3.
        drive(4'b0001, 1'b0, 1'b0);
        step(1);
        check("t3_pre_id", 32'(bus.gnt_id), 0);
        bus.done = 1'b1;
        step(1);
        drive(4'b1111, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("t3_rr_id", 32'(bus.gnt_id), 32'(rr_exp[i]));
            check("t3_rr_valid", 32'(bus.gnt_valid), 1);
            bus.done = 1'b1;
            step(1);
            check("t3_rr_gap", 32'(bus.gnt), 0);
            bus.done = 1'b0;
        end
        drive(4'b0000, 1'b0, 1'b0);
        step(2);

        // Timeout: held request with no done.
        drive(4'b0001, 1'b0, 1'b0);
        step(1);
        cnt = 0;
        while (bus.gnt_valid && cnt < 40) begin
            cnt++;
            step(1);
        end
        check("t4_valid_cycles", 32'(cnt), 15);
        check("t4_timeout", 32'(bus.timeout), 1);
        step(1);
        check("t4_regrant_id", 32'(bus.gnt_id), 0);
        check("t4_regrant_valid", 32'(bus.gnt_valid), 1);
        check("t4_pulse_end", 32'(bus.timeout), 0);
        bus.req = '0;
        step(2);

        // done coinciding with counter expiry is a normal release.
        drive(4'b0001, 1'b0, 1'b0);
        step(1);
        step(14);
        bus.done = 1'b1;
        step(1);
        check("t4b_gnt", 32'(bus.gnt), 0);
        check("t4b_timeout", 32'(bus.timeout), 0);
        drive(4'b0000, 1'b0, 1'b0);
        step(2);

        // Holder drops its request.
        drive(4'b1011, 1'b0, 1'b0);
        step(1);
        check("t5_id", 32'(bus.gnt_id), 3);
        bus.req = 4'b0011;
        step(1);
        check("t5_gnt", 32'(bus.gnt), 0);
        check("t5_timeout", 32'(bus.timeout), 0);
        step(1);
        check("t5_next_id", 32'(bus.gnt_id), 1);
        bus.req = '0;
        step(2);

        // Reset in the middle of a grant.
        drive(4'b0010, 1'b0, 1'b0);
        step(1);
        check("t6_id", 32'(bus.gnt_id), 1);
        rst = 1'b1;
        step(1);
        check("t6_gnt", 32'(bus.gnt), 0);
        check("t6_timeout", 32'(bus.timeout), 0);
        check("t6_rr_ptr", 32'(bus.rr_ptr_dbg), 0);
        rst = 1'b0;
        drive(4'b0011, 1'b0, 1'b1);
        step(1);
        check("t6_rr_id", 32'(bus.gnt_id), 0);
        check("t6_rr_valid", 32'(bus.gnt_valid), 1);
        bus.req = '0;
        step(3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
